// File: rtl/agc_arith_if.sv
// Request/result bundle between the control-pulse decoder and agc_arith_unit.
interface agc_arith_if #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 5
);
  logic             req;
  logic [2:0]       op;
  logic [WIDTH-1:0] din;
  logic [CNTW-1:0]  cnt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] a;
  logic             ovf;
  logic             eac;

  modport master (
    output req, op, din, cnt,
    input  busy, done, a, ovf, eac
  );

  modport slave (
    input  req, op, din, cnt,
    output busy, done, a, ovf, eac
  );
endinterface

// File: rtl/agc_arith_unit.sv
// Ones'-complement A-register unit with its own micro-sequencer.
// AGC_EAC_EN: fold end-around carry into sums (else two's-complement wrap).
module agc_arith_unit #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 5
) (
  input logic        CLOCK,
  input logic        rst_,
  input logic        gojam,
  agc_arith_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    XY,
    SUM,
    SHIFT,
    DONE
  } state_t;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_INCR = 3'd3;
  localparam logic [2:0] OP_CYR  = 3'd4;
  localparam logic [2:0] OP_CYL  = 3'd5;
  localparam logic [2:0] OP_NOP  = 3'd7;

  state_t           state_q;
  state_t           state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] din_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] a_q;
  logic [CNTW-1:0]  ctr_q;
  logic             eac_q;

  logic [WIDTH:0]   raw;
  logic [WIDTH-1:0] sum;
  logic             go_xy;
  logic             go_shift;
  logic             go_done;

  always_comb begin
    raw = {1'b0, x_q} + {1'b0, y_q};
`ifdef AGC_EAC_EN
    sum = raw[WIDTH-1:0]
        + {{(WIDTH-1){1'b0}}, raw[WIDTH]};
`else
    sum = raw[WIDTH-1:0];
`endif
  end

  // Mutually exclusive dispatch of an accepted request
  assign go_xy    = ~bus.op[2];
  assign go_shift = bus.op[2] & (bus.op != OP_NOP)
                  & (bus.cnt != '0);
  assign go_done  = bus.op[2] & ((bus.op == OP_NOP)
                  | (bus.cnt == '0));

  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          unique case (1'b1)
            go_xy:    state_d = XY;
            go_shift: state_d = SHIFT;
            go_done:  state_d = DONE;
            default:  state_d = IDLE;
          endcase
        end
      end
      XY:    state_d = SUM;
      SUM:   state_d = DONE;
      SHIFT: if (ctr_q == CNTW'(1)) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (gojam) state_d = IDLE;
  end

  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      op_q  <= '0;
      din_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      a_q   <= '0;
      ctr_q <= '0;
      eac_q <= 1'b0;
    end else if (gojam) begin
      a_q   <= '0;
      eac_q <= 1'b0;
      ctr_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req) begin
            op_q  <= bus.op;
            din_q <= bus.din;
            ctr_q <= bus.cnt;
          end
        end
        XY: begin
          case (op_q)
            OP_LOAD: begin
              x_q <= '0;
              y_q <= din_q;
            end
            OP_ADD: begin
              x_q <= a_q;
              y_q <= din_q;
            end
            OP_SUB: begin
              x_q <= a_q;
              y_q <= ~din_q;
            end
            OP_INCR: begin
              x_q <= a_q;
              y_q <= WIDTH'(1);
            end
            default: ;
          endcase
        end
        SUM: begin
          a_q <= sum;
          // LOAD goes through the adder but must not disturb eac
          if (op_q != OP_LOAD) eac_q <= raw[WIDTH];
        end
        SHIFT: begin
          case (op_q)
            OP_CYR:  a_q <= {a_q[0], a_q[WIDTH-1:1]};
            OP_CYL:  a_q <= {a_q[WIDTH-2:0], a_q[WIDTH-1]};
            default: a_q <= {a_q[WIDTH-1], a_q[WIDTH-1:1]};
          endcase
          ctr_q <= ctr_q - CNTW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.a    = a_q;
  assign bus.ovf  = a_q[WIDTH-1] ^ a_q[WIDTH-2];
  assign bus.eac  = eac_q;

endmodule

// File: tb/tb_agc_arith_unit.sv
// Bench for agc_arith_unit: directed plan, random ops vs arithmetic model,
// abort, busy and reset cases.
module tb_agc_arith_unit;

  localparam int W = 16;
  localparam int C = 5;

  logic CLOCK;
  logic rst_;
  logic gojam;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] m_a;
  logic         m_eac;

  agc_arith_if #(.WIDTH(W), .CNTW(C)) bus ();

  agc_arith_unit #(.WIDTH(W), .CNTW(C)) dut (
    .CLOCK (CLOCK),
    .rst_  (rst_),
    .gojam (gojam),
    .bus   (bus)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h",
             tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation rules
  task automatic model(input logic [2:0] op,
                       input logic [W-1:0] din,
                       input logic [C-1:0] cnt);
    longint unsigned s, y, c, r;
    int unsigned v;
    v = m_a;
    case (op)
      3'd0: m_a = din;
      3'd1, 3'd2, 3'd3: begin
        if (op == 3'd1)      y = din;
        else if (op == 3'd2) y = 65535 - din;
        else                 y = 1;
        s = longint'(m_a) + y;
        c = s / 65536;
        r = s % 65536;
`ifdef AGC_EAC_EN
        r = (r + c) % 65536;
`endif
        m_a   = W'(r);
        m_eac = (c != 0);
      end
      3'd4, 3'd5, 3'd6: begin
        for (int i = 0; i < int'(cnt); i++) begin
          if (op == 3'd4)
            v = (v / 2) + (v % 2) * 32768;
          else if (op == 3'd5)
            v = ((v * 2) % 65536) + (v / 32768);
          else
            v = (v / 2) + (v / 32768) * 32768;
        end
        m_a = W'(v);
      end
      default: ;
    endcase
  endtask

  function automatic int lat(input logic [2:0] op,
                             input logic [C-1:0] cnt);
    if (op < 3'd4)  return 2;
    if (op == 3'd7) return 0;
    return int'(cnt);
  endfunction

  // Called just after a rising edge with the unit idle
  task automatic do_op(input logic [2:0] op,
                       input logic [W-1:0] din,
                       input logic [C-1:0] cnt);
    int l;
    bus.req = 1'b1;
    bus.op  = op;
    bus.din = din;
    bus.cnt = cnt;
    @(posedge CLOCK);
    #1;
    bus.req = 1'b0;
    model(op, din, cnt);
    l = lat(op, cnt);
    if (l == 0) begin
      chk("done_at_accept", 32'(bus.done), 1);
    end else begin
      chk("busy_after_accept", 32'(bus.busy), 1);
      for (int k = 1; k <= l; k++) begin
        @(posedge CLOCK);
        #1;
        chk("done_timing", 32'(bus.done), 32'(k == l));
      end
    end
    chk("a", 32'(bus.a), 32'(m_a));
    chk("eac", 32'(bus.eac), 32'(m_eac));
    chk("ovf", 32'(bus.ovf), 32'(m_a[W-1] ^ m_a[W-2]));
    @(posedge CLOCK);
    #1;
    chk("done_falls", 32'(bus.done), 0);
    chk("idle_again", 32'(bus.busy), 0);
  endtask

  initial begin
    int n_done;
    int done_at;
    rst_    = 1'b0;
    gojam   = 1'b0;
    bus.req = 1'b0;
    bus.op  = '0;
    bus.din = '0;
    bus.cnt = '0;
    m_a     = '0;
    m_eac   = 1'b0;
    repeat (3) @(posedge CLOCK);
    #1;
    chk("rst_a", 32'(bus.a), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_eac", 32'(bus.eac), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    rst_ = 1'b1;
    @(posedge CLOCK);
    #1;

    // Directed plan
    do_op(3'd0, 16'h0005, 5'd0);
    do_op(3'd1, 16'hFFFD, 5'd0);
`ifdef AGC_EAC_EN
    chk("plan_add_eac", 32'(bus.a), 32'h0003);
`else
    chk("plan_add_wrap", 32'(bus.a), 32'h0002);
`endif
    chk("plan_add_carry", 32'(bus.eac), 1);
    do_op(3'd0, 16'h0001, 5'd0);
    do_op(3'd2, 16'h0001, 5'd0);
    chk("plan_minus_zero", 32'(bus.a), 32'hFFFF);
    do_op(3'd0, 16'h3FFF, 5'd0);
    do_op(3'd3, 16'h0000, 5'd0);
    chk("plan_incr_ovf", 32'(bus.ovf), 1);
    do_op(3'd0, 16'h8001, 5'd0);
    do_op(3'd4, 16'h0000, 5'd3);
    chk("plan_cyr3", 32'(bus.a), 32'h3000);
    do_op(3'd6, 16'h0000, 5'd1);
    chk("plan_sr1", 32'(bus.a), 32'h1800);
    do_op(3'd5, 16'h0000, 5'd0);
    do_op(3'd7, 16'hABCD, 5'd9);
    do_op(3'd0, 16'h8421, 5'd0);
    do_op(3'd6, 16'h0000, 5'd20);

    // Random operations
    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)),
            W'($urandom),
            C'($urandom_range(0, 31)));
    end

    // Abort during SUM
    do_op(3'd0, 16'h1234, 5'd0);
    bus.req = 1'b1;
    bus.op  = 3'd1;
    bus.din = 16'h0101;
    @(posedge CLOCK);
    #1;
    bus.req = 1'b0;
    @(posedge CLOCK);
    #1;
    gojam = 1'b1;
    @(posedge CLOCK);
    #1;
    gojam = 1'b0;
    m_a   = '0;
    m_eac = 1'b0;
    chk("abort_a", 32'(bus.a), 32'(m_a));
    chk("abort_eac", 32'(bus.eac), 32'(m_eac));
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_idle", 32'(bus.busy), 0);
    @(posedge CLOCK);
    #1;
    chk("abort_no_late_done", 32'(bus.done), 0);

    // req together with gojam is refused
    gojam   = 1'b1;
    bus.req = 1'b1;
    bus.op  = 3'd0;
    bus.din = 16'h5A5A;
    @(posedge CLOCK);
    #1;
    gojam   = 1'b0;
    bus.req = 1'b0;
    chk("gojam_req_busy", 32'(bus.busy), 0);
    chk("gojam_req_a", 32'(bus.a), 0);
    @(posedge CLOCK);
    #1;
    chk("gojam_req_done", 32'(bus.done), 0);

    // req toggling while shifting
    do_op(3'd0, W'($urandom), 5'd0);
    bus.req = 1'b1;
    bus.op  = 3'd5;
    bus.cnt = 5'd10;
    @(posedge CLOCK);
    #1;
    model(3'd5, '0, 5'd10);
    n_done  = 0;
    done_at = 0;
    bus.op  = 3'd0;
    for (int k = 1; k <= 12; k++) begin
      bus.req = (k < 10) ? 1'(k % 2) : 1'b0;
      bus.din = W'($urandom);
      @(posedge CLOCK);
      #1;
      if (bus.done) begin
        n_done++;
        done_at = k;
      end
    end
    chk("busy_one_done", 32'(n_done), 1);
    chk("busy_done_edge", 32'(done_at), 10);
    chk("busy_a", 32'(bus.a), 32'(m_a));
    chk("busy_idle", 32'(bus.busy), 0);

    // Reset mid-shift
    do_op(3'd0, 16'hC3C3, 5'd0);
    do_op(3'd1, 16'hC3C3, 5'd0);
    bus.req = 1'b1;
    bus.op  = 3'd4;
    bus.cnt = 5'd10;
    @(posedge CLOCK);
    #1;
    bus.req = 1'b0;
    repeat (3) @(posedge CLOCK);
    #3;
    rst_ = 1'b0;
    #1;
    m_a   = '0;
    m_eac = 1'b0;
    chk("mid_rst_a", 32'(bus.a), 32'(m_a));
    chk("mid_rst_eac", 32'(bus.eac), 32'(m_eac));
    chk("mid_rst_ovf", 32'(bus.ovf), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    @(posedge CLOCK);
    #1;
    rst_ = 1'b1;
    @(posedge CLOCK);
    #1;
    chk("post_rst_done", 32'(bus.done), 0);
    do_op(3'd3, 16'h0000, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
